// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the dual-clock FIFO, entirely in the rclk domain.
// Hides the one-cycle rdata latency behind a small skid buffer and presents a valid/ready stream.
module fifo_rd_stream #(
   parameter int DWIDTH     = 8,
   parameter int SKID_DEPTH = 3,
   parameter int CWIDTH     = 16
) (
   input  logic              rclk,
   input  logic              reset_L,
   input  logic              enable,
   input  logic              fifo_empty,
   output logic              fifo_pop,
   input  logic [DWIDTH-1:0] fifo_rdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DWIDTH-1:0] m_data,
   output logic [2:0]        level,
   output logic [CWIDTH-1:0] words_out
);

   localparam logic [2:0] DEPTH    = 3'(SKID_DEPTH);
   localparam logic [1:0] LAST_PTR = 2'(SKID_DEPTH - 1);

   logic [DWIDTH-1:0] mem_q [SKID_DEPTH];
   logic [1:0]        head_q, head_d;
   logic [1:0]        tail_q, tail_d;
   logic [2:0]        occ_q, occ_d;
   logic              inflight_q;
   logic [CWIDTH-1:0] words_q, words_d;
   logic              handshake;
   logic [3:0]        committed;

   // Space is reserved for the word already in flight, so a pop never depends on m_ready.
   // NOTE: reset_L gates the pop directly so the FIFO sees no request while reset is held.
   assign committed = {1'b0, occ_q} + {3'b000, inflight_q};
   assign fifo_pop  = reset_L & enable & ~fifo_empty & (committed < {1'b0, DEPTH});

   assign m_valid   = (occ_q != 3'd0);
   assign m_data    = m_valid ? mem_q[head_q] : '0;
   assign handshake = m_valid & m_ready;
   assign level     = occ_q;
   assign words_out = words_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      words_d = words_q;
      if (inflight_q) begin
         tail_d = (tail_q == LAST_PTR) ? 2'd0 : tail_q + 2'd1;
      end
      if (handshake) begin
         head_d  = (head_q == LAST_PTR) ? 2'd0 : head_q + 2'd1;
         words_d = words_q + CWIDTH'(1);
      end
      occ_d = occ_q + 3'(inflight_q) - 3'(handshake);
   end

   // NOTE: non-blocking assignments in every clocked process so all state updates see pre-edge values.
   always_ff @(posedge rclk or negedge reset_L) begin
      if (!reset_L) begin
         head_q     <= 2'd0;
         tail_q     <= 2'd0;
         occ_q      <= 3'd0;
         inflight_q <= 1'b0;
         words_q    <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         inflight_q <= fifo_pop;
         words_q    <= words_d;
      end
   end

   // NOTE: storage is not reset; occ_q alone decides which entries are meaningful.
   always_ff @(posedge rclk) begin
      if (inflight_q) begin
         mem_q[tail_q] <= fifo_rdata;
      end
   end

   occ_bound : assert property (@(posedge rclk) disable iff (!reset_L) occ_q <= DEPTH);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a queue models the FIFO read port with one-cycle rdata latency.
module tb_fifo_rd_stream;

   logic        rclk = 1'b0;
   logic        reset_L = 1'b0;
   logic        enable = 1'b1;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_rdata = 8'h00;
   logic        m_ready = 1'b0;
   logic        fifo_pop, m_valid;
   logic [7:0]  m_data;
   logic [2:0]  level;
   logic [15:0] words_out;
   logic        fifo_pop_w, m_valid_w;
   logic [7:0]  m_data_w;
   logic [2:0]  level_w;
   logic [3:0]  words_out_w;

   logic [7:0]  fifo_q [$];
   int errors = 0;
   int checks = 0;
   int pops = 0;
   int underflows = 0;

   always #5 rclk = ~rclk;

   fifo_rd_stream #(.DWIDTH(8), .SKID_DEPTH(3), .CWIDTH(16)) dut (
      .rclk(rclk), .reset_L(reset_L), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .level(level), .words_out(words_out)
   );

   // Same stimulus, narrow counter, to observe wrap-around.
   fifo_rd_stream #(.DWIDTH(8), .SKID_DEPTH(3), .CWIDTH(4)) dut_w (
      .rclk(rclk), .reset_L(reset_L), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_pop(fifo_pop_w), .fifo_rdata(fifo_rdata), .m_valid(m_valid_w), .m_ready(m_ready),
      .m_data(m_data_w), .level(level_w), .words_out(words_out_w)
   );

   // One clock cycle, entered and left at the falling edge; the FIFO model answers a pop after the edge.
   task automatic tick();
      logic popped;
      #1;
      popped = fifo_pop;
      @(posedge rclk);
      #1;
      if (popped && reset_L) begin
         pops++;
         if (fifo_q.size() == 0) begin
            underflows++;
            fifo_rdata = 8'hxx;
         end else begin
            fifo_rdata = fifo_q.pop_front();
         end
      end
      fifo_empty = (fifo_q.size() == 0);
      @(negedge rclk);
   endtask

   task automatic push(input logic [7:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic test_reset();
      reset_L = 1'b0;
      enable  = 1'b1;
      m_ready = 1'b0;
      for (int i = 1; i <= 16; i++) push(8'(i));
      repeat (3) @(negedge rclk);
      checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", fifo_pop); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_out); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
      checks++;
      if ({fifo_pop_w, m_valid_w, m_data_w, level_w, words_out_w} !== 17'd0) begin
         errors++;
         $display("FAIL reset_narrow: got pop=%b valid=%b data=%h level=%0d words=%0d want all 0",
                  fifo_pop_w, m_valid_w, m_data_w, level_w, words_out_w);
      end
      reset_L = 1'b1;
      #1;
      checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL release_pop: got %b want 1", fifo_pop); end
   endtask

   task automatic test_streaming();
      int n;
      m_ready = 1'b1;
      n = 0;
      while (m_valid !== 1'b1 && n < 5) begin tick(); n++; end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stream_start: got valid=%b want 1 within 5 cycles", m_valid); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 8'(i + 1)) begin
            errors++;
            $display("FAIL stream_word%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, 8'(i + 1));
         end
         tick();
      end
      checks++; if (words_out !== 16'd16) begin errors++; $display("FAIL stream_words: got %0d want 16", words_out); end
      checks++; if (words_out_w !== 4'd0) begin errors++; $display("FAIL stream_words_narrow: got %0d want 0", words_out_w); end
      checks++; if (m_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL stream_drained: got valid=%b level=%0d want 0/0", m_valid, level); end
      checks++; if (pops != 16 || fifo_q.size() != 0) begin errors++; $display("FAIL stream_pops: got pops=%0d left=%0d want 16/0", pops, fifo_q.size()); end
   endtask

   task automatic test_backpressure();
      int p0;
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
      p0 = pops;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (m_valid === 1'b1 && m_data !== 8'hA0) begin errors++; $display("FAIL bp_hold%0d: got %h want a0", i, m_data); end
      end
      checks++; if (pops - p0 != 3) begin errors++; $display("FAIL bp_pops: got %0d want 3", pops - p0); end
      checks++; if (level !== 3'd3) begin errors++; $display("FAIL bp_level: got %0d want 3", level); end
      checks++; if (m_valid !== 1'b1 || m_data !== 8'hA0) begin errors++; $display("FAIL bp_head: got valid=%b data=%h want 1/a0", m_valid, m_data); end
      checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL bp_nopop: got %b want 0", fifo_pop); end
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 8'hA0 + 8'(i)) begin
            errors++;
            $display("FAIL bp_word%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, 8'hA0 + 8'(i));
         end
         tick();
         if (i == 0) begin
            checks++; if (words_out_w !== 4'd1) begin errors++; $display("FAIL wrap17: got %0d want 1", words_out_w); end
         end
      end
      checks++; if (words_out !== 16'd24) begin errors++; $display("FAIL bp_words: got %0d want 24", words_out); end
      checks++; if (pops - p0 != 8 || level !== 3'd0) begin errors++; $display("FAIL bp_end: got pops=%0d level=%0d want 8/0", pops - p0, level); end
   endtask

   task automatic test_enable_gating();
      int p0;
      int n;
      m_ready = 1'b1;
      enable  = 1'b1;
      for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
      p0 = pops;
      #1;
      checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL en_firstpop: got %b want 1", fifo_pop); end
      tick();
      enable = 1'b0;
      #1;
      checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL en_gated: got %b want 0", fifo_pop); end
      tick();
      checks++; if (m_valid !== 1'b1 || m_data !== 8'hB0) begin errors++; $display("FAIL en_inflight: got valid=%b data=%h want 1/b0", m_valid, m_data); end
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL en_drained: got %b want 0", m_valid); end
      repeat (3) tick();
      checks++; if (pops - p0 != 1 || fifo_pop !== 1'b0) begin errors++; $display("FAIL en_held: got pops=%0d pop=%b want 1/0", pops - p0, fifo_pop); end
      enable = 1'b1;
      n = 0;
      while (m_valid !== 1'b1 && n < 5) begin tick(); n++; end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 8'hB0 + 8'(i)) begin
            errors++;
            $display("FAIL en_word%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, 8'hB0 + 8'(i));
         end
         tick();
      end
      checks++; if (words_out !== 16'd28 || level !== 3'd0) begin errors++; $display("FAIL en_end: got words=%0d level=%0d want 28/0", words_out, level); end
   endtask

   task automatic test_empty_edge();
      int p0;
      m_ready = 1'b0;
      push(8'hC5);
      p0 = pops;
      #1;
      checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL empty_pop: got %b want 1", fifo_pop); end
      tick();
      checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL empty_stop: got %b want 0", fifo_pop); end
      tick();
      checks++; if (level !== 3'd1 || m_valid !== 1'b1 || m_data !== 8'hC5) begin
         errors++; $display("FAIL empty_word: got level=%0d valid=%b data=%h want 1/1/c5", level, m_valid, m_data);
      end
      tick();
      checks++; if (m_data !== 8'hC5 || fifo_pop !== 1'b0) begin errors++; $display("FAIL empty_hold: got data=%h pop=%b want c5/0", m_data, fifo_pop); end
      m_ready = 1'b1;
      tick();
      checks++; if (level !== 3'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL empty_after: got level=%0d valid=%b want 0/0", level, m_valid); end
      checks++; if (pops - p0 != 1 || underflows != 0) begin errors++; $display("FAIL empty_count: got pops=%0d underflows=%0d want 1/0", pops - p0, underflows); end
      checks++; if (words_out !== 16'd29 || words_out_w !== 4'd13) begin errors++; $display("FAIL empty_words: got %0d/%0d want 29/13", words_out, words_out_w); end
   endtask

   task automatic test_reset_midstream();
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
      repeat (3) tick();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_prevalid: got %b want 1", m_valid); end
      #2;
      reset_L = 1'b0;
      fifo_q.delete();
      fifo_empty = 1'b1;
      fifo_rdata = 8'h00;
      #1;
      checks++; if (level !== 3'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got level=%0d valid=%b want 0/0", level, m_valid); end
      checks++; if (words_out !== 16'd0 || words_out_w !== 4'd0) begin errors++; $display("FAIL mid_words: got %0d/%0d want 0/0", words_out, words_out_w); end
      checks++; if (fifo_pop !== 1'b0 || m_data !== 8'h00) begin errors++; $display("FAIL mid_outputs: got pop=%b data=%h want 0/00", fifo_pop, m_data); end
      @(negedge rclk);
      reset_L = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (m_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL mid_idle%0d: got valid=%b level=%0d want 0/0", i, m_valid, level); end
      end
      checks++; if (underflows != 0) begin errors++; $display("FAIL underflow: got %0d want 0", underflows); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_enable_gating();
      test_empty_edge();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1);
   end

endmodule
